// File: rtl/rv_fetch_pkg.sv
// -----------------------------------------------------------------------------
// rv_fetch_pkg
// Shared definitions for the instruction-fetch front end.
//   NOP_INSTR        : word presented on instr_out when nothing is valid
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_entry_t    : one buffered fetch result {pc, instr}
// -----------------------------------------------------------------------------
package rv_fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Synchronous FIFO of fetch_entry_t with a combinational head view.
//   clk, rst    : clock, asynchronous active-high reset (pointers/count only)
//   push        : write push_entry at the tail
//   pop         : retire the head entry
//   flush       : empty the FIFO (wins over push/pop)
//   head_entry  : current head (meaningful only when !empty)
//   empty       : no entries held
//   occupancy   : number of entries held (0..BUF_DEPTH)
// The caller guarantees no push when full and no pop when empty.
// -----------------------------------------------------------------------------
module fetch_buffer
    import rv_fetch_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    localparam int PW = $clog2(BUF_DEPTH),
    localparam int CW = $clog2(BUF_DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head_entry,
    output logic         empty,
    output logic [CW-1:0] occupancy
);

    fetch_entry_t  entry_q [BUF_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          write_en;

    assign write_en = push && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Depth is a power of two, so pointers wrap naturally.
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (write_en && (wr_ptr_q == PW'(gi))) begin
                entry_q[gi] <= push_entry;
            end
        end
    end

    assign head_entry = entry_q[rd_ptr_q];
    assign empty      = (count_q == '0);
    assign occupancy  = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch front end: generates the PC stream, issues word requests
// over a req/gnt/rvalid handshake, buffers returned words and presents the
// head to the IF/ID register. A redirect flushes buffered and in-flight
// fetches and restarts at the new target.
//   clk, rst          : clock, asynchronous active-high reset
//   stall             : decode holding; head not consumed
//   redirect          : taken branch/jump; flush and refetch
//   redirect_pc       : new target, bits [1:0] forced to zero
//   imem_req/addr     : fetch request and word address
//   imem_gnt          : request accepted this cycle
//   imem_rvalid/rdata : in-order response
//   instr_out/pc_out  : head instruction and PC (zero when not valid)
//   instr_valid       : head presentable this cycle
// -----------------------------------------------------------------------------
module if_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;

    // PC tags of in-flight requests, in issue order. Not flushed on redirect:
    // dropped responses still retire their tag so the order stays aligned.
    logic [31:0]   tag_q [BUF_DEPTH];
    logic [PW-1:0] tag_wr_q, tag_wr_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d;

    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;
    logic          buf_empty;
    logic [CW-1:0] buf_occ;
    logic          buf_push;
    logic          pop;
    logic          grant;
    logic          rsp;
    logic [CW:0]   credit_used;
    logic          redirect_pc_unused;

    assign redirect_pc_unused = ^redirect_pc[1:0];

    assign instr_valid = !buf_empty && !redirect;
    assign pop         = instr_valid && !stall;
    assign instr_out   = instr_valid ? head_entry.instr : NOP_INSTR;
    assign pc_out      = instr_valid ? head_entry.pc    : 32'h0;

    // Credit: every granted request has a guaranteed buffer slot, counting
    // the slot freed by this cycle's pop.
    assign credit_used = {1'b0, buf_occ} + {1'b0, outstanding_q} - (CW + 1)'(pop);
    assign imem_req    = !rst && !redirect && (credit_used < (CW + 1)'(BUF_DEPTH));
    assign imem_addr   = fetch_pc_q;
    assign grant       = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol violation; ignore it.
    assign rsp      = imem_rvalid && (outstanding_q != '0);
    assign buf_push = rsp && (drop_q == '0) && !redirect;

    assign push_entry.pc    = tag_q[tag_rd_q];
    assign push_entry.instr = imem_rdata;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(grant) - CW'(rsp);
        drop_d        = drop_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;

        if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            tag_wr_d   = tag_wr_q + PW'(1);
        end
        if (rsp) begin
            tag_rd_d = tag_rd_q + PW'(1);
        end

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            // Everything still in flight after this edge is on the abandoned
            // path. Pending drops are already part of outstanding, so the new
            // drop count is exactly the updated outstanding count.
            drop_d = outstanding_d;
        end else if (rsp && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
        end
    end

    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_tag
        always_ff @(posedge clk) begin
            if (grant && (tag_wr_q == PW'(gi))) begin
                tag_q[gi] <= fetch_pc_q;
            end
        end
    end

    fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (buf_push),
        .pop        (pop),
        .flush      (redirect),
        .push_entry (push_entry),
        .head_entry (head_entry),
        .empty      (buf_empty),
        .occupancy  (buf_occ)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed vector table, hand sequences (address wrap, mid-run reset) and a
// randomized phase, all checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam int          BUF_DEPTH = 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .instr_valid (instr_valid)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        logic [31:0] pc;
        logic        drop;
    } fly_t;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        rvh;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: expected fetch PC, delivered-but-unconsumed words,
    // and requests in flight (marked when abandoned by a redirect).
    logic [31:0] m_pc = RESET_PC;
    entry_t      m_buf[$];
    fly_t        m_fly[$];
    logic [31:0] mem_q[$];

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;

    vec_t vecs[22];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic rvh, input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.rvh = rvh;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Called at posedge+1: drive one cycle, check mid-cycle, advance model.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic g, input logic rvh);
        logic   exp_valid, exp_pop, exp_req, grant, rv;
        entry_t e;
        fly_t   f;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_gnt    = g;
        if (mem_q.size() > 0 && !rvh) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #4;
        exp_valid = (m_buf.size() > 0) && !rd;
        exp_pop   = exp_valid && !st;
        exp_req   = !rd && ((m_buf.size() + m_fly.size() - (exp_pop ? 1 : 0)) < BUF_DEPTH);
        s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid; s_pc = pc_out;

        chk($sformatf("c%0d imem_req", cyc), imem_req, exp_req);
        if (exp_req) chk($sformatf("c%0d imem_addr", cyc), imem_addr, m_pc);
        chk($sformatf("c%0d instr_valid", cyc), instr_valid, exp_valid);
        if (exp_valid) begin
            chk($sformatf("c%0d pc_out", cyc), pc_out, m_buf[0].pc);
            chk($sformatf("c%0d instr_out", cyc), instr_out, m_buf[0].instr);
        end else begin
            chk($sformatf("c%0d pc_out_idle", cyc), pc_out, 32'h0);
            chk($sformatf("c%0d instr_out_idle", cyc), instr_out, 32'h0);
        end
        if (exp_pop) $display("xfer c%0d pc=%h instr=%h", cyc, pc_out, instr_out);

        // memory side
        if (imem_rvalid) void'(mem_q.pop_front());
        if (imem_req && imem_gnt) mem_q.push_back(imem_addr);

        // model
        grant = exp_req && g;
        rv    = imem_rvalid && (m_fly.size() > 0);
        if (exp_pop) void'(m_buf.pop_front());
        if (rv) begin
            f = m_fly.pop_front();
            if (!f.drop && !rd) begin
                e.pc    = f.pc;
                e.instr = mem_word(f.pc);
                m_buf.push_back(e);
            end
        end
        if (grant) begin
            f.pc   = m_pc;
            f.drop = 1'b0;
            m_fly.push_back(f);
            m_pc = m_pc + 32'd4;
        end
        if (rd) begin
            m_buf.delete();
            foreach (m_fly[i]) m_fly[i].drop = 1'b1;
            m_pc = {rpc[31:2], 2'b00};
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        //              st rd rpc           rvh req addr          valid pc
        vecs[0]  = mk(0, 0, 32'h0,       0, 1, 32'h0000_0000, 0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0,       0, 1, 32'h0000_0004, 0, 32'h0);
        vecs[2]  = mk(0, 0, 32'h0,       0, 1, 32'h0000_0008, 1, 32'h0000_0000);
        vecs[3]  = mk(0, 0, 32'h0,       0, 1, 32'h0000_000C, 1, 32'h0000_0004);
        vecs[4]  = mk(1, 0, 32'h0,       0, 1, 32'h0000_0010, 1, 32'h0000_0008);
        vecs[5]  = mk(1, 0, 32'h0,       0, 1, 32'h0000_0014, 1, 32'h0000_0008);
        vecs[6]  = mk(1, 0, 32'h0,       0, 0, 32'h0,         1, 32'h0000_0008);
        vecs[7]  = mk(1, 0, 32'h0,       0, 0, 32'h0,         1, 32'h0000_0008);
        vecs[8]  = mk(0, 0, 32'h0,       0, 1, 32'h0000_0018, 1, 32'h0000_0008);
        vecs[9]  = mk(0, 0, 32'h0,       0, 1, 32'h0000_001C, 1, 32'h0000_000C);
        vecs[10] = mk(0, 0, 32'h0,       1, 1, 32'h0000_0020, 1, 32'h0000_0010);
        vecs[11] = mk(0, 1, 32'h102,     1, 0, 32'h0,         0, 32'h0);
        vecs[12] = mk(0, 0, 32'h0,       0, 1, 32'h0000_0100, 0, 32'h0);
        vecs[13] = mk(0, 0, 32'h0,       0, 1, 32'h0000_0104, 0, 32'h0);
        vecs[14] = mk(0, 0, 32'h0,       0, 1, 32'h0000_0108, 0, 32'h0);
        vecs[15] = mk(0, 0, 32'h0,       0, 1, 32'h0000_010C, 1, 32'h0000_0100);
        vecs[16] = mk(0, 0, 32'h0,       0, 1, 32'h0000_0110, 1, 32'h0000_0104);
        vecs[17] = mk(0, 1, 32'h200,     0, 0, 32'h0,         0, 32'h0);
        vecs[18] = mk(0, 0, 32'h0,       0, 1, 32'h0000_0200, 0, 32'h0);
        vecs[19] = mk(0, 0, 32'h0,       0, 1, 32'h0000_0204, 0, 32'h0);
        vecs[20] = mk(0, 0, 32'h0,       0, 1, 32'h0000_0208, 1, 32'h0000_0200);
        vecs[21] = mk(0, 0, 32'h0,       0, 1, 32'h0000_020C, 1, 32'h0000_0204);

        // reset state while rst is held
        @(posedge clk);
        #1;
        chk("reset imem_req", imem_req, 1'b0);
        chk("reset instr_valid", instr_valid, 1'b0);
        chk("reset pc_out", pc_out, 32'h0);
        chk("reset instr_out", instr_out, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // directed table: stream, stall/credit, redirects with drops
        foreach (vecs[i]) begin
            step(vecs[i].st, vecs[i].rd, vecs[i].rpc, 1'b1, vecs[i].rvh);
            chk($sformatf("vec%0d req", i), s_req, vecs[i].e_req);
            if (vecs[i].e_req) chk($sformatf("vec%0d addr", i), s_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d valid", i), s_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d pc", i), s_pc, vecs[i].e_pc);
        end

        // address wrap past 0xFFFF_FFFC (low target bits ignored)
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("wrap redirect req", s_req, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("wrap req hi", s_req, 1'b1);
        chk("wrap addr hi", s_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("wrap addr lo", s_addr, 32'h0000_0000);

        // fill three entries under stall, then reset mid-operation
        for (int i = 0; i < 20 && m_buf.size() != 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("three buffered", m_buf.size(), 3);
        rst   = 1'b1;
        stall = 1'b0;
        #1;
        chk("midrst instr_valid", instr_valid, 1'b0);
        chk("midrst instr_out", instr_out, 32'h0);
        chk("midrst pc_out", pc_out, 32'h0);
        chk("midrst imem_req", imem_req, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        m_pc = RESET_PC;
        m_buf.delete();
        m_fly.delete();
        mem_q.delete();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("post-reset req", s_req, 1'b1);
        chk("post-reset addr", s_addr, RESET_PC);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 3,
                 $urandom_range(0, 19) == 0,
                 $urandom,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
